// File: rtl/vga_timing_stage.sv
// 640x480@60 decode of the 800x525 pixel/line counter. Issues pixel fetch requests and
// delays sync/blank to match the source latency, so rgb, syncs and blank_n leave aligned.
module vga_timing_stage #(
  parameter int unsigned PIPE         = 2,
  parameter logic [11:0] UNDERRUN_RGB = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [9:0]  req_x,
  output logic [8:0]  req_y,
  output logic        req_valid,
  input  logic [11:0] pix_data,
  input  logic        pix_valid,
  input  logic        clr_err,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [11:0] rgb,
  output logic        frame_start,
  output logic [7:0]  frame_count,
  output logic        underrun
);

  logic w_in_range;
  logic w_active;
  logic w_hs_n;
  logic w_vs_n;
  logic w_sof;

  // Coordinates outside the 800x525 raster must never produce a sync pulse.
  assign w_in_range = (x < 10'd800) && (y < 10'd525);
  assign w_active   = (x < 10'd640) && (y < 10'd480);
  assign w_hs_n     = !(w_in_range && (x >= 10'd656) && (x <= 10'd751));
  assign w_vs_n     = !(w_in_range && (y >= 10'd490) && (y <= 10'd491));
  assign w_sof      = (x == 10'd0) && (y == 10'd0);

  logic [9:0] r_req_x;
  logic [8:0] r_req_y;
  logic       r_req_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_valid <= 1'b0;
      r_req_x     <= 10'd0;
      r_req_y     <= 9'd0;
    end else begin
      r_req_valid <= w_active;
      if (w_active) begin
        r_req_x <= x;
        r_req_y <= y[8:0];
      end
    end
  end

  // Stage PIPE is the tap consumed together with the source data returned PIPE clocks later.
  logic [PIPE:0] r_act_d;
  logic [PIPE:0] r_hs_d;
  logic [PIPE:0] r_vs_d;
  logic [PIPE:0] r_sof_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act_d <= '0;
      r_hs_d  <= '1;
      r_vs_d  <= '1;
      r_sof_d <= '0;
    end else begin
      r_act_d <= {r_act_d[PIPE-1:0], w_active};
      r_hs_d  <= {r_hs_d[PIPE-1:0],  w_hs_n};
      r_vs_d  <= {r_vs_d[PIPE-1:0],  w_vs_n};
      r_sof_d <= {r_sof_d[PIPE-1:0], w_sof};
    end
  end

  logic w_tap_act;
  logic w_tap_sof;

  assign w_tap_act = r_act_d[PIPE];
  assign w_tap_sof = r_sof_d[PIPE];

  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank_n;
  logic [11:0] r_rgb;
  logic        r_frame_start;
  logic [7:0]  r_frame_count;
  logic        r_underrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_rgb         <= 12'd0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
      r_underrun    <= 1'b0;
    end else begin
      r_hsync       <= r_hs_d[PIPE];
      r_vsync       <= r_vs_d[PIPE];
      r_blank_n     <= w_tap_act;
      r_frame_start <= w_tap_sof;
      if (w_tap_act) begin
        r_rgb <= pix_valid ? pix_data : UNDERRUN_RGB;
      end else begin
        r_rgb <= 12'd0;
      end
      // A new underrun outranks a clear arriving on the same clock.
      if (w_tap_act && !pix_valid) begin
        r_underrun <= 1'b1;
      end else if (clr_err) begin
        r_underrun <= 1'b0;
      end
      if (w_tap_sof) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign req_x       = r_req_x;
  assign req_y       = r_req_y;
  assign req_valid   = r_req_valid;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank_n     = r_blank_n;
  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_vga_timing_stage.sv
// Bench for vga_timing_stage at PIPE = 2, 1 and 7 sharing one x/y/reset stream; each
// instance has a fixed-latency pixel source and a queue-based reference model.
module tb_vga_timing_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic       clr_err = 1'b0;
  bit         drop_rand_en = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input int p, input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (PIPE=%0d) t=%0t: got %0d, expected %0d", nm, p, $time, act, exp);
    end
  endtask

  function automatic bit f_act(input int a, input int b);
    return (a < 640) && (b < 480);
  endfunction

  function automatic bit f_hsn(input int a, input int b);
    return !((a <= 799) && (b <= 524) && (a >= 656) && (a <= 751));
  endfunction

  function automatic bit f_vsn(input int a, input int b);
    return !((a <= 799) && (b <= 524) && (b >= 490) && (b <= 491));
  endfunction

  logic [11:0] rgb_m [3];
  logic        fs_m  [3];
  logic [7:0]  fc_m  [3];
  logic        bl_m  [3];
  logic        ur_m  [3];

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int P = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

    logic [9:0]  req_x;
    logic [8:0]  req_y;
    logic        req_valid;
    logic [11:0] pix_data = 12'd0;
    logic        pix_valid = 1'b0;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic [11:0] rgb;
    logic        frame_start;
    logic [7:0]  frame_count;
    logic        underrun;

    vga_timing_stage #(.PIPE(P), .UNDERRUN_RGB(12'hF0F)) u_dut (
      .clk(clk), .rst(rst_n), .x(x), .y(y),
      .req_x(req_x), .req_y(req_y), .req_valid(req_valid),
      .pix_data(pix_data), .pix_valid(pix_valid), .clr_err(clr_err),
      .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .rgb(rgb),
      .frame_start(frame_start), .frame_count(frame_count), .underrun(underrun)
    );

    assign rgb_m[g] = rgb;
    assign fs_m[g]  = frame_start;
    assign fc_m[g]  = frame_count;
    assign bl_m[g]  = blank_n;
    assign ur_m[g]  = underrun;

    // History of the last P+1 sampled coordinates; 1023 marks a reset-filled slot.
    logic [9:0] qx[$];
    logic [9:0] qy[$];
    int e_hs = 1, e_vs = 1, e_bl = 0, e_rgb = 0, e_fs = 0, e_fc = 0, e_ur = 0;
    int e_rv = 0, e_rx = 0, e_ry = 0;

    always @(posedge clk) begin : p_model
      logic [9:0] tx, ty, fx, fy;
      bit pv, drp;
      int pd;
      pv = pix_valid;
      pd = pix_data;
      if (!rst_n) begin
        qx = {};
        qy = {};
        for (int i = 0; i <= P; i++) begin
          qx.push_back(10'd1023);
          qy.push_back(10'd1023);
        end
        e_hs = 1; e_vs = 1; e_bl = 0; e_rgb = 0; e_fs = 0; e_fc = 0; e_ur = 0;
        e_rv = 0; e_rx = 0; e_ry = 0;
      end else begin
        tx = qx.pop_front();
        ty = qy.pop_front();
        e_bl  = f_act(tx, ty);
        e_hs  = f_hsn(tx, ty);
        e_vs  = f_vsn(tx, ty);
        e_fs  = (tx == 0 && ty == 0);
        e_rgb = e_bl ? (pv ? pd : 'hF0F) : 0;
        if (e_bl && !pv) e_ur = 1;
        else if (clr_err) e_ur = 0;
        if (e_fs) e_fc = (e_fc + 1) % 256;
        e_rv = f_act(x, y);
        if (e_rv) begin
          e_rx = x;
          e_ry = y % 512;
        end
        qx.push_back(x);
        qy.push_back(y);
      end
      #1;
      check(P, "hsync", hsync, e_hs);
      check(P, "vsync", vsync, e_vs);
      check(P, "blank_n", blank_n, e_bl);
      check(P, "rgb", rgb, e_rgb);
      check(P, "frame_start", frame_start, e_fs);
      check(P, "frame_count", frame_count, e_fc);
      check(P, "underrun", underrun, e_ur);
      check(P, "req_valid", req_valid, e_rv);
      check(P, "req_x", req_x, e_rx);
      check(P, "req_y", req_y, e_ry);
      // Source: data for the coordinate sampled P edges ago, valid for the next edge.
      fx = qx[0];
      fy = qy[0];
      if (f_act(fx, fy)) begin
        drp = ((fx == 10 || fx == 30) && fy == 5) ||
              (drop_rand_en && $urandom_range(0, 31) == 0);
        pix_valid = !drp;
        pix_data  = drp ? 12'($urandom) : {fx[3:0], fy[3:0], 4'h0};
      end else begin
        pix_valid = 1'($urandom);
        pix_data  = 12'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int nx, input int ny, input bit c);
    #1;
    x = nx[9:0];
    y = ny[9:0];
    clr_err = c;
  endtask

  task automatic step(input bit c);
    #1;
    if (x >= 10'd799) begin
      x = 10'd0;
      y = (y >= 10'd524) ? 10'd0 : y + 10'd1;
    end else begin
      x = x + 10'd1;
    end
    clr_err = c;
  endtask

  task automatic go_to(input int tx, input int ty);
    int k = 0;
    while (!(x == tx[9:0] && y == ty[9:0]) && k < 6000) begin
      tick();
      step(1'b0);
      k++;
    end
    check(0, "go_to_reached", int'(x == tx[9:0] && y == ty[9:0]), 1);
  endtask

  int xs [6] = '{0, 630, 650, 745, 790, 500};
  int ys [7] = '{0, 478, 488, 489, 491, 523, 524};
  bit seen [3];

  initial begin
    // Reset held while coordinates toggle.
    repeat (10) begin
      tick();
      drive($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom));
    end
    tick();
    drive(0, 0, 1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      step(1'b0);
    end
    tick();
    check(2, "first_frame_start", fs_m[0], 1);
    check(2, "first_blank_n", bl_m[0], 1);
    check(2, "first_frame_count", fc_m[0], 1);
    step(1'b0);

    // Forced underrun at pixel (10,5), then clear alone.
    go_to(10, 5);
    repeat (3) begin
      tick();
      step(1'b0);
    end
    tick();
    check(2, "underrun_rgb", rgb_m[0], 'hF0F);
    check(2, "underrun_set", ur_m[0], 1);
    step(1'b1);
    tick();
    check(2, "clr_alone", ur_m[0], 0);
    step(1'b0);

    // Underrun at (30,5) coinciding with clr_err.
    go_to(30, 5);
    tick(); step(1'b0);
    tick(); step(1'b0);
    tick(); step(1'b1);
    tick();
    check(2, "set_beats_clr", ur_m[0], 1);
    step(1'b1);
    tick();
    check(2, "clr_after", ur_m[0], 0);
    step(1'b0);

    // Frame counter wrap: 254 more frame starts reach 255, one more wraps to 0.
    repeat (254) begin
      tick();
      drive(0, 0, 1'b0);
    end
    repeat (10) begin
      tick();
      drive(100, 100, 1'b0);
    end
    for (int i = 0; i < 3; i++) check(i, "fc_255", fc_m[i], 255);
    tick();
    drive(0, 0, 1'b0);
    repeat (10) begin
      tick();
      drive(100, 100, 1'b0);
    end
    for (int i = 0; i < 3; i++) check(i, "fc_wrap", fc_m[i], 0);

    // Randomized phase: sequential runs from boundary points and random jumps.
    drop_rand_en = 1'b1;
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat (100) begin
          tick();
          drive($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 15) == 0);
        end
      end else begin
        tick();
        drive(xs[$urandom_range(0, 5)], ys[$urandom_range(0, 6)], 1'b0);
        repeat ($urandom_range(200, 600)) begin
          tick();
          step($urandom_range(0, 15) == 0);
        end
      end
    end
    drop_rand_en = 1'b0;

    // Mid-frame reset at (300,200), released 5 clocks later at (0,0).
    tick();
    drive(300, 200, 1'b0);
    repeat (20) begin
      tick();
      step(1'b0);
    end
    #1;
    rst_n = 1'b0;
    repeat (5) tick();
    drive(0, 0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) seen[i] = 1'b0;
    repeat (12) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (!seen[i]) check(i, "no_stale_rgb", rgb_m[i], 0);
        if (fs_m[i]) seen[i] = 1'b1;
      end
      step(1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      check(i, "restart_frame_start_seen", seen[i], 1);
      check(i, "restart_frame_count", fc_m[i], 1);
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
